// File: rtl/sum_accumulator_if.sv
// Operand/result stream bundle for sum_accumulator: burst request, operand
// valid/ready channel and result valid/ready channel.
interface sum_accumulator_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_of;
    logic             busy;

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_of, busy
    );

    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_of, busy
    );
endinterface

// File: rtl/sum_accumulator.sv
// Streaming signed accumulator: sums a burst of len operands, tracking last carry-out
// and sticky signed overflow. Define SUM_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module sum_accumulator #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    sum_accumulator_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cout_q, cout_d;
    logic             of_q, of_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [WIDTH:0]   sum_c;
    logic             ov_c;
    logic             accept_c;
    logic             out_hs_c;

    // Unsigned WIDTH+1 add gives the carry; overflow from operand/result sign bits.
    always_comb begin
        sum_c    = {1'b0, acc_q} + {1'b0, bus.in_data};
        ov_c     = (acc_q[WIDTH-1] == bus.in_data[WIDTH-1]) &&
                   (sum_c[WIDTH-1] != acc_q[WIDTH-1]);
        accept_c = in_ready_q & bus.in_valid;
        out_hs_c = out_valid_q & bus.out_ready;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
        of_d    = of_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    cout_d  = 1'b0;
                    of_d    = 1'b0;
                    cnt_d   = bus.len;
                    state_d = (bus.len == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept_c) begin
                    cout_d = sum_c[WIDTH];
                    of_d   = of_q | ov_c;
                    acc_d  = sum_c[WIDTH-1:0];
`ifdef SUM_ACC_SATURATE_EN
                    // On overflow both operands share a sign; clamp toward it.
                    if (ov_c) begin
                        acc_d = bus.in_data[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                     : {1'b0, {(WIDTH-1){1'b1}}};
                    end
`endif
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_hs_c) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they track state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            cout_q      <= 1'b0;
            of_q        <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            cout_q      <= cout_d;
            of_q        <= of_d;
            in_ready_q  <= (state_d == S_ACCUM);
            out_valid_q <= (state_d == S_DONE);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = acc_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_of    = of_q;
    assign bus.busy      = busy_q;

endmodule
